// File: rtl/dmem_responder.sv
// Data memory responder: single-cycle stores, loads answered after
// WAIT_STATES extra cycles with sign/zero extension by funct3.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic        dmem_valid,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   widx;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ext;
  logic            unused_addr;

  assign unused_addr = ^addr[31:AW+2];
  assign widx        = addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          idx_d   = addr[AW+1:2];
          off_d   = addr[1:0];
          f3_d    = funct3;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end else if (store) begin
          wr_en = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read from the request that will be latched, so WAIT_STATES=0 works too
  always_comb begin
    rword = mem[idx_d];
    case (off_d)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = off_d[1] ? rword[31:16] : rword[15:0];
    case (f3_d)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'd0, rbyte};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = rword;
    endcase
    rdata_d = rdata_q;
    if (state_d == RESP && state_q != RESP) begin
      rdata_d = ext;
    end
  end

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{wdata[7:0]}};
      end
      3'b001: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign dmem_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rdata      = rdata_q;

endmodule
